pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage MIPS32 core. Merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg and the stage latches. Sequences exception/ERET redirection by issuing a one-cycle flush with the redirect PC. Holds the pipeline during a post-reset boot window and tracks stall statistics.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_stall_watchdog.sv | 33 +++
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, FSM states,
// the ERET exception code and the reset polarity.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXCEPT_ERET = 32'h0000000e;
    localparam logic        RST_ENABLE  = 1'b0;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    // The deepest requesting stage wins: stalling it must also hold everything upstream.
    function automatic logic [STALL_W-1:0] stall_merge(input logic id, input logic ex,
                                                       input logic mem);
        if (mem)     return STALL_MEM;
        else if (ex) return STALL_EX;
        else if (id) return STALL_ID;
        else         return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Saturating count of consecutive stalled cycles with a sticky trip flag.
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic timeout
);

    localparam logic [15:0] TRIP = 16'(LIMIT - 1);

    logic [15:0] count;

    // The flag rises on the edge that completes the LIMIT-th stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            count   <= 16'd0;
            timeout <= 1'b0;
        end else begin
            if (clr)
                count <= 16'd0;
            else if (inc && count != 16'hFFFF)
                count <= count + 16'd1;
            if (inc && count >= TRIP)
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: boot hold, stall-vector merge, one-cycle exception/ERET
// flush with redirect PC, and stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          BOOT_HOLD   = 4,
    parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
    parameter int          STALL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    state_t      state, state_next;
    logic [3:0]  boot_cnt;
    logic        exc_req;
    logic        run_stalled;
    logic        wd_clr;

    assign exc_req     = (state == ST_RUN) && (excepttype != 32'd0);
    assign run_stalled = (state == ST_RUN) && stall[0];
    assign wd_clr      = ((state == ST_RUN) && !stall[0]) || (state == ST_FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) state <= ST_BOOT;
        else                   state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = STALL_ALL;
        case (state)
            ST_BOOT: begin
                stall = STALL_ALL;
                if (boot_cnt == 4'(BOOT_HOLD - 1))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                stall = stall_merge(stallreq_id, stallreq_ex, stallreq_mem);
                if (excepttype != 32'd0)
                    state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                stall      = STALL_NONE;
                state_next = ST_RUN;
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            boot_cnt     <= 4'd0;
            flush        <= 1'b0;
            new_pc       <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (state == ST_BOOT) boot_cnt <= boot_cnt + 4'd1;
            else                  boot_cnt <= 4'd0;
            flush <= exc_req;
            // new_pc is only loaded on a redirect and otherwise keeps its last value.
            if (exc_req)
                new_pc <= (excepttype == EXCEPT_ERET) ? cp0_epc : EXC_VECTOR;
            if (run_stalled)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    pipe_ctrl_stall_watchdog #(
        .LIMIT(STALL_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .inc    (run_stalled),
        .clr    (wd_clr),
        .timeout(stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot hold, stall priority, exception and ERET
// redirect, watchdog trip and reset during a flush.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype, cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int tests_run = 0;
    int fails     = 0;

    pipe_ctrl #(
        .BOOT_HOLD  (4),
        .EXC_VECTOR (32'h00000020),
        .STALL_LIMIT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype   (excepttype),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (stall !== 6'b111111) begin fails++; $display("FAIL reset_stall got %b exp %b", stall, 6'b111111); end
        tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush); end
        tests_run++; if (new_pc !== 32'd0) begin fails++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
        tests_run++; if (stall_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", stall_timeout); end
        tests_run++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
    endtask

    task automatic test_boot(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (stall !== 6'b111111) begin fails++; $display("FAIL %s_hold%0d got %b exp %b", tag, i, stall, 6'b111111); end
            tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL %s_flush%0d got %b exp 0", tag, i, flush); end
            tick();
        end
        tests_run++; if (stall !== 6'b000000) begin fails++; $display("FAIL %s_run_stall got %b exp %b", tag, stall, 6'b000000); end
        tests_run++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL %s_no_count got %0d exp 0", tag, stall_cycles); end
    endtask

    task automatic test_stall_priority();
        stallreq_id = 1'b1; stallreq_ex = 1'b1;
        #1;
        tests_run++; if (stall !== 6'b001111) begin fails++; $display("FAIL prio_id_ex got %b exp %b", stall, 6'b001111); end
        tick();
        stallreq_mem = 1'b1;
        #1;
        tests_run++; if (stall !== 6'b011111) begin fails++; $display("FAIL prio_mem got %b exp %b", stall, 6'b011111); end
        tick();
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        #1;
        tests_run++; if (stall !== 6'b000000) begin fails++; $display("FAIL prio_none got %b exp %b", stall, 6'b000000); end
        tests_run++; if (stall_cycles !== 32'd2) begin fails++; $display("FAIL prio_count got %0d exp 2", stall_cycles); end
        tick();
        stallreq_id = 1'b1;
        #1;
        tests_run++; if (stall !== 6'b000111) begin fails++; $display("FAIL prio_id got %b exp %b", stall, 6'b000111); end
        tick();
        stallreq_id = 1'b0;
        #1;
        tests_run++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL prio_count_id got %0d exp 3", stall_cycles); end
        tick();
    endtask

    task automatic test_exception();
        stallreq_ex = 1'b1; excepttype = 32'h0000000c;
        tick();
        // Keep the code asserted across the flush edge: it must not retrigger.
        tests_run++; if (flush !== 1'b1) begin fails++; $display("FAIL exc_flush got %b exp 1", flush); end
        tests_run++; if (new_pc !== 32'h00000020) begin fails++; $display("FAIL exc_new_pc got %h exp %h", new_pc, 32'h00000020); end
        tests_run++; if (stall !== 6'b000000) begin fails++; $display("FAIL exc_stall got %b exp %b", stall, 6'b000000); end
        tests_run++; if (stall_cycles !== 32'd4) begin fails++; $display("FAIL exc_count got %0d exp 4", stall_cycles); end
        tick();
        excepttype = 32'd0;
        #1;
        tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL exc_one_pulse got %b exp 0", flush); end
        tests_run++; if (stall !== 6'b001111) begin fails++; $display("FAIL exc_resume_stall got %b exp %b", stall, 6'b001111); end
        tests_run++; if (new_pc !== 32'h00000020) begin fails++; $display("FAIL exc_pc_hold got %h exp %h", new_pc, 32'h00000020); end
        tests_run++; if (stall_cycles !== 32'd4) begin fails++; $display("FAIL exc_no_count_flush got %0d exp 4", stall_cycles); end
        tick();
        stallreq_ex = 1'b0;
        #1;
        tests_run++; if (stall_cycles !== 32'd5) begin fails++; $display("FAIL exc_count_after got %0d exp 5", stall_cycles); end
        tick();
    endtask

    task automatic test_eret();
        cp0_epc = 32'hBFC00100; excepttype = 32'h0000000e;
        tick();
        excepttype = 32'd0; cp0_epc = 32'h12345678;
        tests_run++; if (flush !== 1'b1) begin fails++; $display("FAIL eret_flush got %b exp 1", flush); end
        tests_run++; if (new_pc !== 32'hBFC00100) begin fails++; $display("FAIL eret_new_pc got %h exp %h", new_pc, 32'hBFC00100); end
        tick();
        tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL eret_one_pulse got %b exp 0", flush); end
        tests_run++; if (new_pc !== 32'hBFC00100) begin fails++; $display("FAIL eret_pc_hold got %h exp %h", new_pc, 32'hBFC00100); end
    endtask

    task automatic test_watchdog();
        stallreq_mem = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            tests_run++;
            if (stall_timeout !== (i >= 8)) begin
                fails++; $display("FAIL wd_cycle%0d got %b exp %b", i, stall_timeout, (i >= 8));
            end
        end
        stallreq_mem = 1'b0;
        tick();
        tests_run++; if (stall_timeout !== 1'b1) begin fails++; $display("FAIL wd_sticky got %b exp 1", stall_timeout); end
        tests_run++; if (stall_cycles !== 32'd15) begin fails++; $display("FAIL wd_count got %0d exp 15", stall_cycles); end
    endtask

    task automatic test_reset_in_flush();
        excepttype = 32'h0000000c;
        tick();
        tests_run++; if (flush !== 1'b1) begin fails++; $display("FAIL rstf_pre_flush got %b exp 1", flush); end
        excepttype = 32'd0;
        rst = 1'b0;
        #1;
        tests_run++; if (flush !== 1'b0) begin fails++; $display("FAIL rstf_flush got %b exp 0", flush); end
        tests_run++; if (stall !== 6'b111111) begin fails++; $display("FAIL rstf_stall got %b exp %b", stall, 6'b111111); end
        tests_run++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL rstf_count got %0d exp 0", stall_cycles); end
        tests_run++; if (stall_timeout !== 1'b0) begin fails++; $display("FAIL rstf_timeout got %b exp 0", stall_timeout); end
        tests_run++; if (new_pc !== 32'd0) begin fails++; $display("FAIL rstf_new_pc got %h exp 0", new_pc); end
        test_boot("reboot");
    endtask

    initial begin
        rst = 1'b0;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excepttype = 32'd0; cp0_epc = 32'd0;
        test_reset();
        test_boot("boot");
        test_stall_priority();
        test_exception();
        test_eret();
        test_watchdog();
        test_reset_in_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
